// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle between the writeback requesters and the register file write port.
// Requesters drive valid/rd/data; the arbiter returns per-requester ready and the registered
// register-file write signals.
interface wb_port_arbiter_if #(
    parameter int NREQ = 3
) ();
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0][4:0]  req_rd;
    logic [NREQ-1:0][31:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  load;
    logic [4:0]            dest;
    logic [31:0]           in;
    logic                  valid_forward;
    logic [2:0]            wb_src;

    // Requester / register-file side of the bundle
    modport master (
        output req_valid, req_rd, req_data,
        input  req_ready, load, dest, in, valid_forward, wb_src
    );

    // Arbiter side of the bundle
    modport slave (
        input  req_valid, req_rd, req_data,
        output req_ready, load, dest, in, valid_forward, wb_src
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter.
// Requester 0 (pipeline WB) normally wins; the other requesters share round-robin and
// a requester that has waited STARVE_MAX cycles overrides requester 0. The winning write
// is registered and presented to the register file one cycle after its handshake.
module wb_port_arbiter #(
    parameter int NREQ       = 3,
    parameter int STARVE_MAX = 7
) (
    input logic              clk,
    input logic              rst,
    wb_port_arbiter_if.slave bus
);
    localparam int CW = 8;

    typedef logic [2:0] idx_t;

    // Wait counters exist only for the non-zero requesters
    logic [NREQ-1:1][CW-1:0] waitCnt_q, waitCnt_d;
    idx_t                    rrPtr_q, rrPtr_d;

    logic [NREQ-1:0] starving;
    logic [NREQ-1:0] waiting;
    logic [3:0]      pickStarve;
    logic [3:0]      pickOther;
    logic            grantAny;
    idx_t            grantIdx;
    logic [NREQ-1:0] grant;
    logic [4:0]      selRd;
    logic [31:0]     selData;

    logic            load_q, load_d;
    logic [4:0]      dest_q, dest_d;
    logic [31:0]     in_q, in_d;
    logic [2:0]      wbSrc_q, wbSrc_d;

    // Round-robin pick among mask bits 1..NREQ-1, searching from ptr+1 and wrapping to 1.
    // Candidates above ptr beat candidates at or below it; within each group the lowest wins.
    // Result bit 3 flags that a candidate was found, bits 2:0 hold its index.
    function automatic logic [3:0] rrPick(input logic [NREQ-1:0] mask, input idx_t ptr);
        logic [3:0] result;
        result = '0;
        for (int j = NREQ - 1; j >= 1; j--) begin
            if (mask[j] && (j <= int'(ptr))) begin
                result = {1'b1, idx_t'(j)};
            end
        end
        for (int j = NREQ - 1; j >= 1; j--) begin
            if (mask[j] && (j > int'(ptr))) begin
                result = {1'b1, idx_t'(j)};
            end
        end
        return result;
    endfunction

    // Grant selection: starving requesters first, then requester 0, then round-robin
    always_comb begin
        starving = '0;
        waiting  = '0;
        grantAny = 1'b0;
        grantIdx = '0;
        grant    = '0;
        for (int i = 1; i < NREQ; i++) begin
            starving[i] = bus.req_valid[i] && (waitCnt_q[i] == CW'(STARVE_MAX));
            waiting[i]  = bus.req_valid[i];
        end
        pickStarve = rrPick(starving, rrPtr_q);
        pickOther  = rrPick(waiting, rrPtr_q);
        if (pickStarve[3]) begin
            grantAny = 1'b1;
            grantIdx = pickStarve[2:0];
        end else if (bus.req_valid[0]) begin
            grantAny = 1'b1;
            grantIdx = '0;
        end else if (pickOther[3]) begin
            grantAny = 1'b1;
            grantIdx = pickOther[2:0];
        end
        // No requester may be released while reset is held
        if (!rst) begin
            grantAny = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = grantAny && (grantIdx == idx_t'(i));
        end
    end

    assign bus.req_ready = grant;

    // Write mux: route the granted requester's destination and data to the output stage
    always_comb begin
        selRd   = '0;
        selData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                selRd   = bus.req_rd[i];
                selData = bus.req_data[i];
            end
        end
    end

    // Next state for wait counters and round-robin pointer; a handshake or idle clears a counter
    always_comb begin
        waitCnt_d = waitCnt_q;
        rrPtr_d   = rrPtr_q;
        for (int i = 1; i < NREQ; i++) begin
            if (!bus.req_valid[i] || grant[i]) begin
                waitCnt_d[i] = '0;
            end else if (waitCnt_q[i] != CW'(STARVE_MAX)) begin
                waitCnt_d[i] = waitCnt_q[i] + CW'(1);
            end
        end
        if (grantAny && (grantIdx != '0)) begin
            rrPtr_d = grantIdx;
        end
    end

    // Next state for the output stage; x0 writes complete the handshake but never load
    always_comb begin
        load_d  = 1'b0;
        dest_d  = dest_q;
        in_d    = in_q;
        wbSrc_d = wbSrc_q;
        if (grantAny) begin
            load_d  = (selRd != 5'd0);
            dest_d  = selRd;
            in_d    = selData;
            wbSrc_d = grantIdx;
        end
    end

    // Arbitration state registers; reset points rr at NREQ-1 so requester 1 wins first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waitCnt_q <= '0;
            rrPtr_q   <= idx_t'(NREQ - 1);
        end else begin
            waitCnt_q <= waitCnt_d;
            rrPtr_q   <= rrPtr_d;
        end
    end

    // Output stage registers; reset discards any captured write immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_q  <= 1'b0;
            dest_q  <= '0;
            in_q    <= '0;
            wbSrc_q <= '0;
        end else begin
            load_q  <= load_d;
            dest_q  <= dest_d;
            in_q    <= in_d;
            wbSrc_q <= wbSrc_d;
        end
    end

    assign bus.load          = load_q;
    assign bus.valid_forward = load_q;
    assign bus.dest          = dest_q;
    assign bus.in            = in_q;
    assign bus.wb_src        = wbSrc_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter with NREQ = 3 and STARVE_MAX = 7.
// Inputs change on the falling edge; req_ready is sampled 1ns later and the registered
// outputs are sampled on the falling edge after the handshake's rising edge.
module tb_wb_port_arbiter;
    localparam int NREQ       = 3;
    localparam int STARVE_MAX = 7;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wb_port_arbiter_if #(.NREQ(NREQ)) bus ();

    wb_port_arbiter #(
        .NREQ      (NREQ),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // 10ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Put the arbiter back in its reset state with all requesters idle
    task automatic doReset();
        rst           = 1'b0;
        bus.req_valid = '0;
        bus.req_rd    = '0;
        bus.req_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Reset with all requesters valid: nothing granted, then requester 0 wins on release
    task automatic test_reset();
        rst           = 1'b0;
        bus.req_valid = 3'b111;
        bus.req_rd[0] = 5'd9;
        bus.req_rd[1] = 5'd1;
        bus.req_rd[2] = 5'd2;
        bus.req_data[0] = 32'h0000_0100;
        bus.req_data[1] = 32'h0000_0111;
        bus.req_data[2] = 32'h0000_0222;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_ready got=%b exp=000", bus.req_ready);
        end
        checks++;
        if (bus.load !== 1'b0 || bus.valid_forward !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_load got=%b/%b exp=0/0", bus.load, bus.valid_forward);
        end
        checks++;
        if (bus.dest !== 5'd0 || bus.in !== 32'd0 || bus.wb_src !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_regs dest=%0d in=%h src=%0d exp=0/0/0", bus.dest, bus.in, bus.wb_src);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 3'b001) begin
            errors++;
            $display("[TB] FAIL release_ready got=%b exp=001", bus.req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = '0;
        checks++;
        if (bus.load !== 1'b1 || bus.dest !== 5'd9 || bus.in !== 32'h0000_0100 || bus.wb_src !== 3'd0) begin
            errors++;
            $display("[TB] FAIL release_write load=%b dest=%0d in=%h src=%0d exp=1/9/00000100/0",
                     bus.load, bus.dest, bus.in, bus.wb_src);
        end
    endtask

    // One write from requester 1 appears on the port the next cycle, then the port holds
    task automatic test_single_write();
        doReset();
        bus.req_valid   = 3'b010;
        bus.req_rd[1]   = 5'd5;
        bus.req_data[1] = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.req_ready !== 3'b010) begin
            errors++;
            $display("[TB] FAIL single_ready got=%b exp=010", bus.req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = '0;
        checks++;
        if (bus.load !== 1'b1 || bus.valid_forward !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_load got=%b/%b exp=1/1", bus.load, bus.valid_forward);
        end
        checks++;
        if (bus.dest !== 5'd5 || bus.in !== 32'hDEAD_BEEF || bus.wb_src !== 3'd1) begin
            errors++;
            $display("[TB] FAIL single_data dest=%0d in=%h src=%0d exp=5/deadbeef/1", bus.dest, bus.in, bus.wb_src);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.load !== 1'b0 || bus.valid_forward !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_load got=%b/%b exp=0/0", bus.load, bus.valid_forward);
        end
        checks++;
        if (bus.dest !== 5'd5 || bus.in !== 32'hDEAD_BEEF || bus.wb_src !== 3'd1) begin
            errors++;
            $display("[TB] FAIL idle_hold dest=%0d in=%h src=%0d exp=5/deadbeef/1", bus.dest, bus.in, bus.wb_src);
        end
    endtask

    // A write to x0 is accepted but never asserts load or the bypass
    task automatic test_x0_write();
        doReset();
        bus.req_valid   = 3'b100;
        bus.req_rd[2]   = 5'd0;
        bus.req_data[2] = 32'h1234_5678;
        #1;
        checks++;
        if (bus.req_ready !== 3'b100) begin
            errors++;
            $display("[TB] FAIL x0_ready got=%b exp=100", bus.req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = '0;
        checks++;
        if (bus.load !== 1'b0 || bus.valid_forward !== 1'b0) begin
            errors++;
            $display("[TB] FAIL x0_load got=%b/%b exp=0/0", bus.load, bus.valid_forward);
        end
        checks++;
        if (bus.wb_src !== 3'd2) begin
            errors++;
            $display("[TB] FAIL x0_src got=%0d exp=2", bus.wb_src);
        end
    endtask

    // Requesters 1 and 2 always valid: grants alternate 1,2,1,2 with load high every cycle
    task automatic test_round_robin();
        logic [2:0] expReady [4] = '{3'b010, 3'b100, 3'b010, 3'b100};
        logic [2:0] expSrc   [4] = '{3'd1, 3'd2, 3'd1, 3'd2};
        doReset();
        bus.req_valid   = 3'b110;
        bus.req_rd[1]   = 5'd11;
        bus.req_rd[2]   = 5'd12;
        bus.req_data[1] = 32'hAAAA_0001;
        bus.req_data[2] = 32'hBBBB_0002;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (bus.req_ready !== expReady[c]) begin
                errors++;
                $display("[TB] FAIL rr_ready cycle=%0d got=%b exp=%b", c, bus.req_ready, expReady[c]);
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.load !== 1'b1 || bus.wb_src !== expSrc[c]) begin
                errors++;
                $display("[TB] FAIL rr_write cycle=%0d load=%b src=%0d exp=1/%0d", c, bus.load, bus.wb_src, expSrc[c]);
            end
        end
        bus.req_valid = '0;
    endtask

    // Requesters 0 and 1 valid: 0 wins cycles 0..6, 1 wins cycle 7, 0 resumes in cycle 8
    task automatic test_starvation();
        logic [2:0] expReady;
        logic [2:0] expSrc;
        doReset();
        bus.req_valid   = 3'b011;
        bus.req_rd[0]   = 5'd3;
        bus.req_rd[1]   = 5'd4;
        bus.req_data[0] = 32'h0000_0030;
        bus.req_data[1] = 32'h0000_0040;
        for (int c = 0; c < 9; c++) begin
            if (c == 8) begin
                bus.req_valid = 3'b001;
            end
            expReady = (c == 7) ? 3'b010 : 3'b001;
            expSrc   = (c == 7) ? 3'd1 : 3'd0;
            #1;
            checks++;
            if (bus.req_ready !== expReady) begin
                errors++;
                $display("[TB] FAIL starve_ready cycle=%0d got=%b exp=%b", c, bus.req_ready, expReady);
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.wb_src !== expSrc || bus.load !== 1'b1) begin
                errors++;
                $display("[TB] FAIL starve_write cycle=%0d src=%0d load=%b exp=%0d/1", c, bus.wb_src, bus.load, expSrc);
            end
        end
        checks++;
        if (bus.dest !== 5'd3) begin
            errors++;
            $display("[TB] FAIL starve_dest got=%0d exp=3", bus.dest);
        end
        bus.req_valid = '0;
    endtask

    // All three valid: 1 and 2 saturate together, round-robin gives 1 then 2, then 0 again
    task automatic test_dual_starve();
        logic [2:0] expReady;
        doReset();
        bus.req_valid = 3'b111;
        bus.req_rd[0] = 5'd20;
        bus.req_rd[1] = 5'd21;
        bus.req_rd[2] = 5'd22;
        for (int c = 0; c < 10; c++) begin
            expReady = (c == 7) ? 3'b010 : (c == 8) ? 3'b100 : 3'b001;
            #1;
            checks++;
            if (bus.req_ready !== expReady) begin
                errors++;
                $display("[TB] FAIL dual_ready cycle=%0d got=%b exp=%b", c, bus.req_ready, expReady);
            end
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (bus.dest !== 5'd20) begin
            errors++;
            $display("[TB] FAIL dual_dest got=%0d exp=20", bus.dest);
        end
        bus.req_valid = '0;
    endtask

    // New write every cycle from requester 0: load stays high and dest/in follow each write
    task automatic test_back_to_back();
        logic [4:0]  rdTab   [3] = '{5'd10, 5'd11, 5'd12};
        logic [31:0] dataTab [3] = '{32'hCAFE_0000, 32'hCAFE_1111, 32'hCAFE_2222};
        doReset();
        bus.req_valid = 3'b001;
        for (int c = 0; c < 3; c++) begin
            bus.req_rd[0]   = rdTab[c];
            bus.req_data[0] = dataTab[c];
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.load !== 1'b1 || bus.dest !== rdTab[c]) begin
                errors++;
                $display("[TB] FAIL b2b_dest cycle=%0d load=%b dest=%0d exp=1/%0d", c, bus.load, bus.dest, rdTab[c]);
            end
            checks++;
            if (bus.in !== dataTab[c]) begin
                errors++;
                $display("[TB] FAIL b2b_data cycle=%0d got=%h exp=%h", c, bus.in, dataTab[c]);
            end
        end
        bus.req_valid = '0;
    endtask

    // Reset asserted just after a handshake: load drops at once and no write follows
    task automatic test_async_reset();
        doReset();
        bus.req_valid   = 3'b010;
        bus.req_rd[1]   = 5'd7;
        bus.req_data[1] = 32'h0000_0055;
        #1;
        checks++;
        if (bus.req_ready !== 3'b010) begin
            errors++;
            $display("[TB] FAIL async_ready got=%b exp=010", bus.req_ready);
        end
        @(posedge clk);
        #2;
        checks++;
        if (bus.load !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_pre_load got=%b exp=1", bus.load);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.load !== 1'b0 || bus.valid_forward !== 1'b0 || bus.req_ready !== 3'b000) begin
            errors++;
            $display("[TB] FAIL async_drop load=%b vf=%b ready=%b exp=0/0/000", bus.load, bus.valid_forward, bus.req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.load !== 1'b0 || bus.dest !== 5'd0) begin
            errors++;
            $display("[TB] FAIL async_no_write load=%b dest=%0d exp=0/0", bus.load, bus.dest);
        end
        @(negedge clk);
        bus.req_valid = '0;
        rst           = 1'b1;
    endtask

    // Run every scenario in sequence and report
    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.req_valid = '0;
        bus.req_rd    = '0;
        bus.req_data  = '0;
        test_reset();
        test_single_write();
        test_x0_write();
        test_round_robin();
        test_starvation();
        test_dual_starve();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL timeout reached exp=finish before 100000ns");
        $fatal(1, "[TB] timeout");
    end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register file's single write port among several writeback sources: the in-order pipeline's WB stage plus multi-cycle units such as the multiplier/divider and a miss-return path. It runs one grant per cycle over valid/ready handshakes and registers the winning write, then drives the register file's load/dest/in/valid_forward inputs one cycle later. Requester 0 (pipeline) has priority. The other requesters share round-robin and are protected from starvation by per-requester wait counters.

## Interface
- NREQ, 3: number of writeback requesters, 2..8; index 0 is the pipeline WB stage.
- STARVE_MAX, 7: wait cycles after which a non-zero requester overrides requester 0; 1..255.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  NREQ  requester i holds a write.
- req_rd  in  NREQ x 5  destination register of requester i.
- req_data  in  NREQ x 32  write data of requester i.
- req_ready  out  NREQ  combinational grant; handshake when req_valid[i] && req_ready[i].
- load  out  1  register-file write enable (registered).
- dest  out  5  register-file write index (registered).
- in  out  32  register-file write data (registered).
- valid_forward  out  1  register-file same-cycle bypass enable (registered).
- wb_src  out  3  index of the requester whose write is on the port (registered; debug/perf).

## Operation
- At most one req_ready bit is high per cycle. It is high only for a requester with req_valid = 1.
- Grant order each cycle:
  - (1) Starving requesters. These are non-zero requesters with wait counter == STARVE_MAX. Round-robin among them.
  - (2) Requester 0 if valid.
  - (3) Other valid non-zero requesters, round-robin.
- Round-robin pointer rr_ptr (1..NREQ-1) holds the last granted non-zero requester. The search starts at rr_ptr+1 and wraps from NREQ-1 to 1. The pointer updates only on a handshake by a non-zero requester.
- Wait counter per non-zero requester:
  - Increments each cycle with valid && !ready.
  - Saturates at STARVE_MAX.
  - Clears on that requester's handshake or when its valid is low.
- Requester 0 has no counter. It can be held off indefinitely only while starvation overrides keep occurring, which is bounded by the round-robin.
- Output stage:
  - On a handshake, captures req_rd and req_data into dest/in and sets wb_src = i.
  - Sets load = valid_forward = (req_rd != 0).
  - With no handshake, load = valid_forward = 0; dest, in and wb_src hold their previous values.
- Writes to x0 complete the handshake (the requester is released) but never assert load or valid_forward.
- The output stage never back-pressures, because the register file accepts every cycle. A grant therefore depends only on arbitration.
- Requesters must keep req_rd and req_data stable while valid && !ready. The arbiter does not check this.

## Timing
- Reset (rst = 0, asynchronous):
  - load = 0, valid_forward = 0, dest = 0, in = 0, wb_src = 0.
  - rr_ptr = NREQ-1, so requester 1 wins the first round-robin.
  - All wait counters = 0.
  - req_ready = 0 throughout reset.
- Reset mid-operation: any write captured but not yet driven is discarded. load drops immediately and asynchronously.
- Latency: a handshake in cycle N gives load/dest/in valid during cycle N+1. The register file commits at the end of N+1, and its bypass covers reads in N+1.
- Throughput: one write per cycle. Back-to-back handshakes give load high continuously with a new dest/in each cycle.
- Simultaneous events:
  - If two or more requesters reach STARVE_MAX in the same cycle, round-robin order applies, and losers stay saturated.
  - If the same requester both handshakes and would increment, the clear takes precedence.
- req_ready is a pure function of the current req_valid, the counters and rr_ptr. There is no path from req_rd or req_data.

## Test plan
- **Reset and idle:** hold rst = 0 with all req_valid = 1, then release. The required response has two parts:
  - During reset: req_ready = 0 and load = 0.
  - First cycle after release: req_ready = 3'b001, since requester 0 wins.
- **Single write:** req_valid = 3'b010, req_rd[1] = 5, req_data[1] = 0xDEADBEEF in cycle N. Required: req_ready = 3'b010 in N; in N+1, load = 1, dest = 5, in = 0xDEADBEEF, valid_forward = 1, wb_src = 1.
- **x0 write:** requester 2 valid with req_rd = 0. Required: handshake in N; load = 0 and valid_forward = 0 in N+1.
- **Round-robin:** requesters 1 and 2 held continuously valid, requester 0 idle. Required: grants alternate 1, 2, 1, 2 starting from requester 1 after reset; load is high every cycle.
- **Starvation:** requesters 0 and 1 held continuously valid, STARVE_MAX = 7. Required:
  - Requester 0 is granted for cycles 0..6.
  - Requester 1 is granted in cycle 7.
  - Requester 1's counter then clears, and requester 0 resumes in cycle 8 if requester 1 drops valid.
- **Async reset mid-stream:** assert rst low mid-cycle, right after a handshake in cycle N. Required: load goes to 0 immediately and no write to the register file occurs in cycle N+1.
